// File: rtl/systolic_feature_loader.sv
// systolic_feature_loader
// Fetches one 2x2 feature window (offsets 0, 1, IMG_W, IMG_W+1 from a base
// address) from feature memory and streams it row-skewed into a 2x2
// weight-stationary systolic array. One launch per rising edge of the enable,
// fixed 9-cycle latency from launch to the done pulse.

module systolic_feature_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int IMG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Feature_Loader_en,
   input  logic [ADDR_W-1:0] systolic_mode_feature_baseaddr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] feat_row0,
   output logic              feat_row0_valid,
   output logic [DATA_W-1:0] feat_row1,
   output logic              feat_row1_valid,
   output logic              busy,
   output logic              feature_Loader_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_READ   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [ADDR_W-1:0] OFF_ROW1    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] OFF_ROW1_P1 = ADDR_W'(IMG_W + 1);

   logic [2:0]        state_q, state_d;
   logic [1:0]        idx_q, idx_d;       // read index in READ, stream phase in STREAM
   logic [ADDR_W-1:0] base_q;
   logic              en_q;
   logic              launch_s;
   logic [ADDR_W-1:0] off_s;
   logic              rd_vld_q;           // read data presented on mem_rdata this cycle
   logic [1:0]        rd_idx_q;           // window slot that data belongs to
   logic [DATA_W-1:0] w0_q, w1_q, w2_q, w3_q;
   logic [DATA_W-1:0] row0_q, row0_d, row1_q, row1_d;
   logic              v0_q, v0_d, v1_q, v1_d;
   logic              busy_q, done_q;

   assign launch_s = (state_q == S_IDLE) && Feature_Loader_en && !en_q;

   // Window offset for the current read index
   always_comb begin
      off_s = {ADDR_W{1'b0}};
      case (idx_q)
         2'd0:    off_s = {ADDR_W{1'b0}};
         2'd1:    off_s = {{(ADDR_W-1){1'b0}}, 1'b1};
         2'd2:    off_s = OFF_ROW1;
         2'd3:    off_s = OFF_ROW1_P1;
         default: off_s = {ADDR_W{1'b0}};
      endcase
   end

   // Memory read strobe and address, decoded straight from state (address wraps)
   always_comb begin
      mem_rd_en = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      if (state_q == S_READ) begin
         mem_rd_en = 1'b1;
         mem_addr  = base_q + off_s;
      end else begin
         mem_rd_en = 1'b0;
         mem_addr  = {ADDR_W{1'b0}};
      end
   end

   // FSM next-state and phase counter
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (launch_s) begin
               state_d = S_READ;
               idx_d   = 2'd0;
            end else begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
            end
         end
         S_READ: begin
            if (idx_q == 2'd3) begin
               state_d = S_WAIT;
               idx_d   = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         S_WAIT: begin
            state_d = S_STREAM;
            idx_d   = 2'd0;
         end
         S_STREAM: begin
            if (idx_q == 2'd2) begin
               state_d = S_DONE;
               idx_d   = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Next values of the array-facing registers: the skew pattern is loaded one cycle ahead
   always_comb begin
      row0_d = {DATA_W{1'b0}};
      v0_d   = 1'b0;
      row1_d = {DATA_W{1'b0}};
      v1_d   = 1'b0;
      if (state_q == S_WAIT) begin
         row0_d = w0_q;
         v0_d   = 1'b1;
      end else if ((state_q == S_STREAM) && (idx_q == 2'd0)) begin
         row0_d = w1_q;
         v0_d   = 1'b1;
         row1_d = w2_q;
         v1_d   = 1'b1;
      end else if ((state_q == S_STREAM) && (idx_q == 2'd1)) begin
         row1_d = w3_q;
         v1_d   = 1'b1;
      end else begin
         row0_d = {DATA_W{1'b0}};
         v0_d   = 1'b0;
         row1_d = {DATA_W{1'b0}};
         v1_d   = 1'b0;
      end
   end

   // Control state: FSM, enable edge detector, base address sampled at launch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         en_q    <= 1'b0;
         base_q  <= {ADDR_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         en_q    <= Feature_Loader_en;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
         if (launch_s) begin
            base_q <= systolic_mode_feature_baseaddr;
         end
      end
   end

   // Capture read data into the window registers one cycle after each read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld_q <= 1'b0;
         rd_idx_q <= 2'd0;
         w0_q     <= {DATA_W{1'b0}};
         w1_q     <= {DATA_W{1'b0}};
         w2_q     <= {DATA_W{1'b0}};
         w3_q     <= {DATA_W{1'b0}};
      end else begin
         rd_vld_q <= mem_rd_en;
         rd_idx_q <= idx_q;
         if (rd_vld_q) begin
            case (rd_idx_q)
               2'd0:    w0_q <= mem_rdata;
               2'd1:    w1_q <= mem_rdata;
               2'd2:    w2_q <= mem_rdata;
               2'd3:    w3_q <= mem_rdata;
               default: w0_q <= w0_q;
            endcase
         end
      end
   end

   // Registered array outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row0_q <= {DATA_W{1'b0}};
         v0_q   <= 1'b0;
         row1_q <= {DATA_W{1'b0}};
         v1_q   <= 1'b0;
      end else begin
         row0_q <= row0_d;
         v0_q   <= v0_d;
         row1_q <= row1_d;
         v1_q   <= v1_d;
      end
   end

   assign feat_row0           = row0_q;
   assign feat_row0_valid     = v0_q;
   assign feat_row1           = row1_q;
   assign feat_row1_valid     = v1_q;
   assign busy                = busy_q;
   assign feature_Loader_done = done_q;

endmodule
